// File: rtl/sc_song_pkg.sv
// Shared constants and FSM encoding for the song-chart metadata server.
//   NUM_NOTES : number of matcher lanes
//   TIME_W    : width of one note time
//   LANE_AW   : address bits inside one lane region (64 notes per lane)
//   LANE_IW   : lane-index bits in the ROM address
//   ADDR_W    : full chart ROM address width
//   NOTE_NONE : end-of-lane sentinel, also the idle link value
package sc_song_pkg;
  localparam int NUM_NOTES = 37;
  localparam int TIME_W    = 16;
  localparam int LANE_AW   = 6;
  localparam int LANE_IW   = 6;
  localparam int ADDR_W    = LANE_IW + LANE_AW;

  localparam logic [TIME_W-1:0] NOTE_NONE = 16'hFFFF;

  typedef enum logic [1:0] {
    S_PICK = 2'd0,
    S_READ = 2'd1,
    S_WB   = 2'd2
  } state_e;
endpackage

// File: rtl/sc_rr_arbiter.sv
// Combinational round-robin picker over the pending lane mask.
//   pending    in  N   lanes waiting for service
//   last_grant in  IW  lane granted most recently
//   grant      out IW  lowest pending lane strictly above last_grant, wrapping
//   any        out 1   at least one lane pending
// The caller registers the grant.
module sc_rr_arbiter
  import sc_song_pkg::*;
#(
  parameter int N  = NUM_NOTES,
  parameter int IW = LANE_IW
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          any
);
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk offsets 1..N from the last grant; the last grant itself is tried last.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, last_grant} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!any && pending[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end
endmodule

// File: rtl/sc_note_metadata_server.sv
// Responder side of the note-matching metadata link. Each lane pulses
// metadata_request to consume its current note time; the block reads that
// lane's next time from the chart ROM and drives it on metadata_link.
//   clk, rst_n        clock, synchronous active-low reset
//   metadata_request  per-lane consume pulse
//   metadata_link     lane i time at [TIME_W*i +: TIME_W]
//   rom_en/rom_addr   chart ROM read strobe and {lane, ptr} address
//   rom_data          ROM data, one cycle after rom_en
//   prefill_done      every lane loaded once since reset
//   lane_exhausted    lane hit sentinel or end of its region
//   overflow_err      sticky: request merged into an already pending lane
module sc_note_metadata_server
  import sc_song_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_NOTES-1:0]        metadata_request,
  output logic [NUM_NOTES*TIME_W-1:0] metadata_link,
  output logic                        rom_en,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [TIME_W-1:0]           rom_data,
  output logic                        prefill_done,
  output logic [NUM_NOTES-1:0]        lane_exhausted,
  output logic                        overflow_err
);
  state_e                                state_q, state_d;
  logic [LANE_IW-1:0]                    lane_q, lane_d;
  logic [NUM_NOTES-1:0][LANE_AW-1:0]     ptr_q, ptr_d;
  logic [NUM_NOTES-1:0][TIME_W-1:0]      link_q, link_d;
  logic [NUM_NOTES-1:0]                  pending_q, pending_d;
  logic [NUM_NOTES-1:0]                  exh_q, exh_d;
  logic [NUM_NOTES-1:0]                  loaded_q, loaded_d;
  logic                                  done_q, done_d;
  logic                                  ovf_q, ovf_d;

  logic [LANE_IW-1:0]   arb_grant;
  logic                 arb_any;
  logic [NUM_NOTES-1:0] lane_oh, rd_mask;

  sc_rr_arbiter #(.N(NUM_NOTES), .IW(LANE_IW)) u_arb (
    .pending    (pending_q),
    .last_grant (lane_q),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  assign lane_oh = NUM_NOTES'(1) << lane_q;
  // A repeat request for the lane currently being read is a fresh request,
  // not a collision: its pending bit is about to be cleared.
  assign rd_mask = (state_q == S_READ) ? lane_oh : '0;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    ptr_d     = ptr_q;
    link_d    = link_q;
    exh_d     = exh_q;
    loaded_d  = loaded_q;
    done_d    = done_q;
    pending_d = pending_q | metadata_request;
    ovf_d     = ovf_q | (|(metadata_request & pending_q & ~rd_mask));
    rom_en    = 1'b0;
    rom_addr  = '0;
    case (state_q)
      S_PICK: begin
        if (arb_any) begin
          lane_d  = arb_grant;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rom_en    = 1'b1;
        rom_addr  = {lane_q, ptr_q[lane_q]};
        pending_d = (pending_q & ~lane_oh) | metadata_request;
        state_d   = S_WB;
      end
      S_WB: begin
        link_d[lane_q] = rom_data;
        // Pointer parks on the sentinel / last slot so later requests re-read it.
        if (rom_data == NOTE_NONE || (&ptr_q[lane_q])) exh_d[lane_q] = 1'b1;
        else ptr_d[lane_q] = ptr_q[lane_q] + LANE_AW'(1);
        loaded_d[lane_q] = 1'b1;
        done_d           = done_q | (&loaded_d);
        state_d          = S_PICK;
      end
      default: state_d = S_PICK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_PICK;
      // Last grant starts at the top lane so prefill begins at lane 0.
      lane_q    <= LANE_IW'(NUM_NOTES-1);
      ptr_q     <= '0;
      link_q    <= {NUM_NOTES{NOTE_NONE}};
      pending_q <= '1;
      exh_q     <= '0;
      loaded_q  <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      ptr_q     <= ptr_d;
      link_q    <= link_d;
      pending_q <= pending_d;
      exh_q     <= exh_d;
      loaded_q  <= loaded_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign metadata_link  = link_q;
  assign prefill_done   = done_q;
  assign lane_exhausted = exh_q;
  assign overflow_err   = ovf_q;
endmodule

// File: tb/tb_sc_note_metadata_server.sv
module tb_sc_note_metadata_server;
  import sc_song_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst_n;
  logic [NUM_NOTES-1:0]        metadata_request;
  logic [NUM_NOTES*TIME_W-1:0] metadata_link;
  logic                        rom_en;
  logic [ADDR_W-1:0]           rom_addr;
  logic [TIME_W-1:0]           rom_data;
  logic                        prefill_done;
  logic [NUM_NOTES-1:0]        lane_exhausted;
  logic                        overflow_err;

  sc_note_metadata_server dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .metadata_request (metadata_request),
    .metadata_link    (metadata_link),
    .rom_en           (rom_en),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .prefill_done     (prefill_done),
    .lane_exhausted   (lane_exhausted),
    .overflow_err     (overflow_err)
  );

  // Chart BRAM: one-cycle registered read.
  logic [TIME_W-1:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  typedef struct {
    int                lane;
    logic [ADDR_W-1:0] addr;
    logic [TIME_W-1:0] data;
    logic              exh;
  } exp_t;

  exp_t q[$];
  exp_t p0, p1;
  bit   v0 = 1'b0, v1 = 1'b0;
  int   vectors = 0, miscompares = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [TIME_W-1:0] link(int i);
    return metadata_link[TIME_W*i +: TIME_W];
  endfunction

  function automatic logic [NUM_NOTES-1:0] oh(int i);
    logic [NUM_NOTES-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic push(int lane, int ptr, logic [TIME_W-1:0] data, logic exh);
    exp_t e;
    e.lane = lane;
    e.addr = ADDR_W'(lane*64 + ptr);
    e.data = data;
    e.exh  = exh;
    q.push_back(e);
  endtask

  task automatic push_prefill();
    for (int i = 0; i < NUM_NOTES; i++)
      push(i, 0, (i == 5) ? 16'd200 : 16'(100 + i), 1'b0);
  endtask

  task automatic pulse(logic [NUM_NOTES-1:0] m);
    @(negedge clk); metadata_request = m;
    @(negedge clk); metadata_request = '0;
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((q.size() != 0 || v0 || v1) && n < budget) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    check("drain_queue", 64'(q.size()), 0);
  endtask

  // Monitor: every ROM read pops one expectation; its link/exhausted result
  // is checked two negedges later, once the write-back edge has passed.
  initial begin
    forever begin
      @(negedge clk);
      if (v1) begin
        check($sformatf("link[%0d]", p1.lane), link(p1.lane), p1.data);
        check($sformatf("exhausted[%0d]", p1.lane), lane_exhausted[p1.lane], p1.exh);
      end
      p1 = p0; v1 = v0; v0 = 1'b0;
      if (rom_en) begin
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_read: addr %0h, none expected", rom_addr);
        end else begin
          p0 = q.pop_front();
          check($sformatf("rom_addr lane %0d", p0.lane), rom_addr, p0.addr);
          v0 = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n;
    for (int l = 0; l < 64; l++)
      for (int k = 0; k < 64; k++)
        rom[l*64+k] = 16'(100 + l + 1000*k);
    rom[5*64+0] = 16'd200;
    rom[5*64+1] = 16'd350;
    rom[5*64+2] = 16'hFFFF;

    rst_n = 1'b0;
    metadata_request = '0;
    repeat (3) @(negedge clk);
    check("rst_link_all", metadata_link == {NUM_NOTES{NOTE_NONE}}, 1);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_prefill_done", prefill_done, 0);
    check("rst_exhausted", lane_exhausted, 0);
    check("rst_overflow", overflow_err, 0);

    // 1: prefill, lane i entry0 = 100+i, done after 37 services.
    push_prefill();
    rst_n = 1'b1;
    repeat (110) @(negedge clk);
    check("prefill_done_early", prefill_done, 0);
    @(negedge clk);
    check("prefill_done_at_111", prefill_done, 1);
    wait_drain(50);
    check("prefill_link0", link(0), 100);
    check("prefill_link36", link(36), 136);
    repeat (20) @(negedge clk);

    // 3: RR order 3,4,20,36 after prefill (last grant 36).
    push(3, 1, 16'd1103, 1'b0);
    push(4, 1, 16'd1104, 1'b0);
    push(20, 1, 16'd1120, 1'b0);
    push(36, 1, 16'd1136, 1'b0);
    @(negedge clk); metadata_request = oh(3) | oh(20) | oh(36);
    @(negedge clk); metadata_request = oh(4);
    @(negedge clk); metadata_request = '0;
    wait_drain(50);

    // 2: lane 5 {200,350,FFFF}; sentinel parks the pointer at 2.
    push(5, 1, 16'd350, 1'b0);
    pulse(oh(5));
    repeat (10) @(negedge clk);
    push(5, 2, 16'hFFFF, 1'b1);
    pulse(oh(5));
    repeat (10) @(negedge clk);
    check("exhausted5", lane_exhausted[5], 1);
    push(5, 2, 16'hFFFF, 1'b1);
    pulse(oh(5));
    wait_drain(50);
    check("link5_none", link(5), 16'hFFFF);
    check("no_overflow_yet", overflow_err, 0);

    // 4: second request for lane 7 while still pending (FSM busy on 6).
    push(6, 1, 16'd1106, 1'b0);
    push(7, 1, 16'd1107, 1'b0);
    @(negedge clk); metadata_request = oh(6) | oh(7);
    @(negedge clk); metadata_request = '0;
    @(negedge clk); metadata_request = oh(7);
    @(negedge clk); metadata_request = '0;
    wait_drain(50);
    check("overflow_set", overflow_err, 1);

    // 6: lane 9 walks to the end of its region and parks at 63.
    for (int j = 1; j <= 64; j++) begin
      int p;
      p = (j < 63) ? j : 63;
      push(9, p, 16'(109 + 1000*p), (j >= 63));
      pulse(oh(9));
      repeat (3) @(negedge clk);
    end
    wait_drain(50);
    check("exhausted9", lane_exhausted[9], 1);

    // 5: reset while lane 2 is in S_READ.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    push(0, 0, 16'd100, 1'b0);
    push(1, 0, 16'd101, 1'b0);
    push(2, 0, 16'hFFFF, 1'b0);
    rst_n = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 50) begin
      @(negedge clk); n++;
      if (rom_en && rom_addr == ADDR_W'(2*64)) found = 1'b1;
    end
    check("abort_point_found", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_link_all", metadata_link == {NUM_NOTES{NOTE_NONE}}, 1);
    check("abort_rom_en", rom_en, 0);
    check("abort_prefill_done", prefill_done, 0);
    check("abort_overflow", overflow_err, 0);
    check("abort_exhausted", lane_exhausted, 0);
    push_prefill();
    rst_n = 1'b1;
    n = 0;
    while (!prefill_done && n < 300) begin
      @(negedge clk); n++;
    end
    check("prefill2_done", prefill_done, 1);
    wait_drain(50);
    check("prefill2_link0", link(0), 100);
    check("prefill2_link36", link(36), 136);
    check("prefill2_exhausted", lane_exhausted, 0);
    repeat (10) @(negedge clk);
    check("final_queue_empty", 64'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
